// File: rtl/serial_arith_shift_div_pow2_controller_pkg.sv
// Shared state encoding and shift-count helpers for the serial arithmetic
// shift / signed power-of-two divide controller.
package arith_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of a count port that must encode every value 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Requests may ask for more shifts than the word has bits; beyond n the
    // result no longer changes, so the count is clamped to n.
    function automatic int sat_count(input int s, input int n);
        return (s > n) ? n : s;
    endfunction

endpackage

// File: rtl/serial_arith_shift_div_pow2_controller_step.sv
// One-bit arithmetic right shift: replicates the sign bit into the MSB and
// exposes the bit that falls off the bottom.
module arith_shift_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    output logic [N-1:0] y_o,
    output logic         out_o
);

    assign y_o   = {a_i[N-1], a_i[N-1:1]};
    assign out_o = a_i[0];

endmodule

// File: rtl/serial_arith_shift_div_pow2_controller.sv
// Iterative sequencer that applies one arithmetic right shift per clock and
// returns either the floor (>>>) or the round-toward-zero (/2**s) result.
module serial_arith_shift_div_pow2_controller
    import arith_shift_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = count_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_a,
    input  logic [SW-1:0] up_s,
    input  logic          up_div,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_res
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. up_ready and down_valid decode registered state only, so no
    // input ever reaches an output combinationally and one op is in flight.

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          sign_q, sign_d;
    logic          sticky_q, sticky_d;

    logic [N-1:0]  acc_shr;
    logic          shift_out;
    logic          round_bit;
    logic [SW-1:0] sat_cnt;

    arith_shift_step #(.N(N)) u_step (
        .a_i   (acc_q),
        .y_o   (acc_shr),
        .out_o (shift_out)
    );

    assign sat_cnt = SW'(sat_count(int'(up_s), N));

    // A negative operand that lost any set bit was floored one step too far;
    // adding one moves the divide result back toward zero.
    assign round_bit = mode_q & sign_q & (sticky_q | shift_out);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        case (state_q)
            ST_IDLE: begin
                if (up_valid) begin
                    acc_d    = up_a;
                    cnt_d    = sat_cnt;
                    mode_d   = up_div;
                    sign_d   = up_a[N-1];
                    sticky_d = 1'b0;
                    state_d  = (sat_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sticky_d = sticky_q | shift_out;
                cnt_d    = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    acc_d   = acc_shr + {{(N-1){1'b0}}, round_bit};
                    state_d = ST_DONE;
                end else begin
                    acc_d = acc_shr;
                end
            end
            ST_DONE: begin
                if (down_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
        end
    end

    assign up_ready   = (state_q == ST_IDLE);
    assign down_valid = (state_q == ST_DONE);
    assign down_res   = acc_q;

endmodule
